ysyx_22040125_hazard_unit: RTL and testbench

- Parametrised successor to the EX-stage forwarding selector: per-channel one-hot operand forwarding (MEM > WB > regfile) for NUM_SRC source channels.
- Adds load-use bubble insertion with a configurable bubble count, and a register scoreboard that tracks outstanding long-latency ops (mul/div) and stalls dependent instructions.
- Sits between ID/EX and the pipeline control. It drives the EX operand muxes and the ID/IF stall and EX flush controls.

---
 rtl/ysyx_22040125_hazard_unit.sv | 214 +++++++++++++++++++++
 tb/tb_ysyx_22040125_hazard_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_hazard_unit.sv
// ysyx_22040125_hazard_unit
// EX-stage hazard control: per-channel operand forwarding (MEM > WB > regfile),
// load-use bubble insertion, and a register scoreboard for long-latency ops
// (mul/div). It drives the EX operand muxes, the ID/IF stall and the EX flush.
//
// Optional build macro: HAZ_SB_DONE_BYPASS_EN
//   defined   - a dependent instruction proceeds in the same cycle its long op
//               completes (the value comes from the WB bypass), and sb_full
//               drops in the completion cycle.
//   undefined - the pending bit must clear at a clock edge before the dependent
//               instruction may proceed (one extra stall cycle).
//
// Scoreboard / bubble state
//   state          | meaning
//   pending[r] = 1 | register r awaits a long-op writeback
//   long_cnt       | number of long ops in flight (0..MAX_LONG)
//   bubble_cnt > 0 | load-use bubbles still to be inserted after the first
//   sb_err = 1     | an illegal issue or done was seen since reset

module ysyx_22040125_hazard_unit #(
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_SRC          = 3,
    parameter int MAX_LONG         = 2,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_rs,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          mem_wen,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          wb_wen,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_wen,
    input  logic                          ex_is_load,
    input  logic [REG_ADDR_W-1:0]         id_rs1,
    input  logic [REG_ADDR_W-1:0]         id_rs2,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_valid,
    input  logic                          id_is_long,
    input  logic                          long_issue,
    input  logic [REG_ADDR_W-1:0]         long_issue_rd,
    input  logic                          long_done,
    input  logic [REG_ADDR_W-1:0]         long_done_rd,
    output logic [NUM_SRC*3-1:0]          fwd_sel,
    output logic                          stall_id,
    output logic                          flush_ex,
    output logic                          sb_full,
    output logic                          sb_err
);

    localparam int SB_DEPTH = 1 << REG_ADDR_W;
    localparam int CNT_W    = $clog2(MAX_LONG + 1);
    localparam int BUB_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_LONG);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [BUB_W-1:0] BUB_ONE    = BUB_W'(1);

    localparam logic [2:0] SEL_RF  = 3'b001;
    localparam logic [2:0] SEL_MEM = 3'b010;
    localparam logic [2:0] SEL_WB  = 3'b100;

    // Registered state
    logic [SB_DEPTH-1:0] pending;
    logic [CNT_W-1:0]    long_cnt;
    logic [BUB_W-1:0]    bubble_cnt;
    logic                sb_err_q;

    // Next-state values
    logic [SB_DEPTH-1:0] pending_nxt;
    logic [CNT_W-1:0]    long_cnt_nxt;
    logic [BUB_W-1:0]    bubble_cnt_nxt;
    logic                sb_err_nxt;

    // ------------------------------------------------------------------
    // Operand forwarding, one independent selector per EX source channel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        logic [REG_ADDR_W-1:0] rs;
        logic [2:0]            sel;

        assign rs = ex_src_rs[g*REG_ADDR_W +: REG_ADDR_W];

        // MEM result is younger than WB, so it wins; x0 is never forwarded
        always_comb begin
            sel = SEL_RF;
            if (mem_wen && (mem_rd != '0) && (rs == mem_rd)) begin
                sel = SEL_MEM;
            end else if (wb_wen && (wb_rd != '0) && (rs == wb_rd)) begin
                sel = SEL_WB;
            end
        end

        assign fwd_sel[g*3 +: 3] = sel;
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic                  load_use_hit;
    logic                  bubble_active;
    logic                  sb_at_cap;
    logic                  sb_hit;
    logic                  structural_hit;
    logic                  hazard;
    logic [REG_ADDR_W-1:0] id_regs [3];
    logic [2:0]            done_bypass;

    assign load_use_hit = id_valid && ex_is_load && ex_wen && (ex_rd != '0) &&
                          ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

    assign bubble_active = (bubble_cnt != '0);
    assign sb_at_cap     = (long_cnt == CNT_MAX);

    // id_rd is included so a younger write cannot overtake an in-flight long op
    assign id_regs[0] = id_rs1;
    assign id_regs[1] = id_rs2;
    assign id_regs[2] = id_rd;

`ifdef HAZ_SB_DONE_BYPASS_EN
    // A register completing this cycle is readable through the WB bypass
    always_comb begin
        done_bypass = '0;
        for (int k = 0; k < 3; k++) begin
            done_bypass[k] = long_done && (long_done_rd == id_regs[k]);
        end
    end

    assign sb_full = sb_at_cap && !long_done;
`else
    assign done_bypass = '0;
    assign sb_full     = sb_at_cap;
`endif

    // Any ID operand still waiting on a long op blocks the instruction
    always_comb begin
        sb_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (id_valid && (id_regs[k] != '0) && pending[id_regs[k]] && !done_bypass[k]) begin
                sb_hit = 1'b1;
            end
        end
    end

    assign structural_hit = id_valid && id_is_long && sb_full;

    assign hazard   = load_use_hit || bubble_active || sb_hit || structural_hit;
    assign stall_id = hazard;
    assign flush_ex = hazard;
    assign sb_err   = sb_err_q;

    // ------------------------------------------------------------------
    // Next-state: bubble counter and scoreboard bookkeeping
    // ------------------------------------------------------------------
    logic issue_ok;
    logic done_ok;
    logic err_evt;

    // Illegal issue/done requests are dropped and only raise the sticky error
    always_comb begin
        issue_ok = long_issue && (!sb_at_cap || long_done);
        done_ok  = long_done && (long_cnt != '0);
        err_evt  = (long_issue && !issue_ok) || (long_done && !done_ok);
    end

    // Load-use bubbles: a hit reloads only when idle, hits during a run are ignored
    always_comb begin
        bubble_cnt_nxt = bubble_cnt;
        if (bubble_active) begin
            bubble_cnt_nxt = bubble_cnt - BUB_ONE;
        end else if (load_use_hit) begin
            bubble_cnt_nxt = BUB_RELOAD;
        end
    end

    // Pending bitmap and in-flight count; on a same-register issue+done the set wins
    always_comb begin
        pending_nxt  = pending;
        long_cnt_nxt = long_cnt;
        sb_err_nxt   = sb_err_q || err_evt;

        if (done_ok) begin
            pending_nxt[long_done_rd] = 1'b0;
        end
        if (issue_ok && (long_issue_rd != '0)) begin
            pending_nxt[long_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;

        case ({issue_ok, done_ok})
            2'b10:   long_cnt_nxt = long_cnt + CNT_ONE;
            2'b01:   long_cnt_nxt = long_cnt - CNT_ONE;
            default: long_cnt_nxt = long_cnt;
        endcase
    end

    // State registers; reset discards every in-flight long op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            long_cnt   <= '0;
            bubble_cnt <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            long_cnt   <= long_cnt_nxt;
            bubble_cnt <= bubble_cnt_nxt;
            sb_err_q   <= sb_err_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_hazard_unit.sv
// Self-checking bench for ysyx_22040125_hazard_unit: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_ysyx_22040125_hazard_unit;

    localparam int AW  = 5;
    localparam int NS  = 3;
    localparam int ML  = 2;
    localparam int LUB = 2;

    localparam logic [NS*3-1:0] FWD_ALL_RF = {NS{3'b001}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*AW-1:0]  ex_src_rs;
    logic [AW-1:0]     mem_rd, wb_rd, ex_rd, id_rs1, id_rs2, id_rd;
    logic [AW-1:0]     long_issue_rd, long_done_rd;
    logic              mem_wen, wb_wen, ex_wen, ex_is_load;
    logic              id_valid, id_is_long, long_issue, long_done;
    logic [NS*3-1:0]   fwd_sel;
    logic              stall_id, flush_ex, sb_full, sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040125_hazard_unit #(
        .REG_ADDR_W(AW), .NUM_SRC(NS), .MAX_LONG(ML), .LOAD_USE_BUBBLES(LUB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ex_src_rs(ex_src_rs),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_valid(id_valid), .id_is_long(id_is_long),
        .long_issue(long_issue), .long_issue_rd(long_issue_rd),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .fwd_sel(fwd_sel), .stall_id(stall_id), .flush_ex(flush_ex),
        .sb_full(sb_full), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ex_src_rs = '0; mem_rd = '0; wb_rd = '0; ex_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        long_issue_rd = '0; long_done_rd = '0;
        mem_wen = 0; wb_wen = 0; ex_wen = 0; ex_is_load = 0;
        id_valid = 0; id_is_long = 0; long_issue = 0; long_done = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_checks++; if (fwd_sel !== FWD_ALL_RF) begin n_fail++; $display("FAIL reset_fwd: got %b want %b", fwd_sel, FWD_ALL_RF); end
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_id); end
        n_checks++; if (flush_ex !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_ex); end
        n_checks++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", sb_full); end
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", sb_err); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (stall_id !== 1'b0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_release: got stall=%b err=%b want 0 0", stall_id, sb_err); end
    endtask

    task automatic test_forwarding();
        do_reset();
        mem_rd = 5'd5; wb_rd = 5'd5; mem_wen = 1; wb_wen = 1;
        ex_src_rs = {5'd6, 5'd0, 5'd5};
        #1;
        n_checks++; if (fwd_sel !== {3'b001, 3'b001, 3'b010}) begin n_fail++; $display("FAIL fwd_mem_prio: got %b want 001001010", fwd_sel); end
        mem_wen = 0;
        #1;
        n_checks++; if (fwd_sel !== {3'b001, 3'b001, 3'b100}) begin n_fail++; $display("FAIL fwd_wb: got %b want 001001100", fwd_sel); end
        ex_src_rs = {5'd6, 5'd0, 5'd0}; mem_rd = 5'd0; wb_rd = 5'd0; mem_wen = 1; wb_wen = 1;
        #1;
        n_checks++; if (fwd_sel !== FWD_ALL_RF) begin n_fail++; $display("FAIL fwd_x0: got %b want %b", fwd_sel, FWD_ALL_RF); end
        mem_rd = 5'd5; wb_rd = 5'd6; ex_src_rs = {5'd6, 5'd5, 5'd5};
        #1;
        n_checks++; if (fwd_sel !== {3'b100, 3'b010, 3'b010}) begin n_fail++; $display("FAIL fwd_mixed: got %b want 100010010", fwd_sel); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd7; id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd7;
        #1;
        n_checks++; if (stall_id !== 1'b1 || flush_ex !== 1'b1) begin n_fail++; $display("FAIL lu_first: got stall=%b flush=%b want 1 1", stall_id, flush_ex); end
        step();
        ex_is_load = 0; ex_wen = 0; ex_rd = 5'd0;
        #1;
        n_checks++; if (stall_id !== 1'b1 || flush_ex !== 1'b1) begin n_fail++; $display("FAIL lu_second: got stall=%b flush=%b want 1 1", stall_id, flush_ex); end
        step();
        n_checks++; if (stall_id !== 1'b0 || flush_ex !== 1'b0) begin n_fail++; $display("FAIL lu_release: got stall=%b flush=%b want 0 0", stall_id, flush_ex); end
        // hit held through the bubble: ignored once, then counts again
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd7;
        step(); step();
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_rehit: got %b want 1", stall_id); end
        step();
        clear_inputs();
        #1;
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_rehit_bubble: got %b want 1", stall_id); end
        step();
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_rehit_release: got %b want 0", stall_id); end
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd0; id_valid = 1; id_rs1 = 5'd0;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b want 0", stall_id); end
        ex_rd = 5'd4; id_rs1 = 5'd4; ex_wen = 0;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_nowen: got %b want 0", stall_id); end
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        do_reset();
        long_issue = 1; long_issue_rd = 5'd10;
        step();
        long_issue = 0;
        step(); step();
        id_valid = 1; id_rs1 = 5'd10;
        #1;
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL sb_raw_stall: got %b want 1", stall_id); end
        id_valid = 0;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL sb_invalid: got %b want 0", stall_id); end
        id_valid = 1;
        step();
        long_done = 1; long_done_rd = 5'd10;
        #1;
`ifdef HAZ_SB_DONE_BYPASS_EN
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL sb_done_cycle: got %b want 0", stall_id); end
`else
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL sb_done_cycle: got %b want 1", stall_id); end
`endif
        step();
        long_done = 0;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL sb_after_done: got %b want 0", stall_id); end
        id_rs1 = 5'd0; id_valid = 0;
        long_issue = 1; long_issue_rd = 5'd12;
        step();
        long_issue = 0; id_valid = 1; id_rd = 5'd12;
        #1;
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL sb_waw: got %b want 1", stall_id); end
        clear_inputs();
    endtask

    task automatic test_capacity();
        do_reset();
        long_issue = 1; long_issue_rd = 5'd3;
        step();
        long_issue_rd = 5'd4;
        step();
        long_issue = 0;
        #1;
        n_checks++; if (sb_full !== 1'b1 || sb_err !== 1'b0) begin n_fail++; $display("FAIL cap_full: got full=%b err=%b want 1 0", sb_full, sb_err); end
        id_valid = 1; id_is_long = 1;
        #1;
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL cap_struct: got %b want 1", stall_id); end
        id_is_long = 0;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL cap_nolong: got %b want 0", stall_id); end
        long_issue = 1; long_issue_rd = 5'd5;
        step();
        long_issue = 0; id_rs1 = 5'd5;
        #1;
        n_checks++; if (sb_err !== 1'b1 || sb_full !== 1'b1) begin n_fail++; $display("FAIL cap_overflow: got err=%b full=%b want 1 1", sb_err, sb_full); end
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL cap_dropped: got %b want 0", stall_id); end
        id_valid = 0;
        long_done = 1; long_done_rd = 5'd3;
        step();
        long_done = 0; id_valid = 1; id_rs1 = 5'd4;
        #1;
        n_checks++; if (sb_full !== 1'b0 || stall_id !== 1'b1) begin n_fail++; $display("FAIL cap_one_left: got full=%b stall=%b want 0 1", sb_full, stall_id); end
        id_valid = 0;
        long_done = 1; long_done_rd = 5'd4;
        step();
        long_done = 0; id_valid = 1;
        #1;
        n_checks++; if (stall_id !== 1'b0 || sb_full !== 1'b0) begin n_fail++; $display("FAIL cap_drained: got stall=%b full=%b want 0 0", stall_id, sb_full); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        long_issue = 1; long_issue_rd = 5'd3;
        step();
        long_done = 1; long_done_rd = 5'd3;
        step();
        long_issue = 0; long_done = 0; id_valid = 1; id_rs1 = 5'd3;
        #1;
        n_checks++; if (stall_id !== 1'b1 || sb_err !== 1'b0 || sb_full !== 1'b0) begin n_fail++; $display("FAIL sim_set_wins: got stall=%b err=%b full=%b want 1 0 0", stall_id, sb_err, sb_full); end
        id_valid = 0;
        long_done = 1;
        step();
        long_done = 0; id_valid = 1;
        #1;
        n_checks++; if (stall_id !== 1'b0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL sim_cnt_one: got stall=%b err=%b want 0 0", stall_id, sb_err); end
        long_done = 1;
        step();
        long_done = 0;
        #1;
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sim_underflow: got %b want 1", sb_err); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        long_issue = 1; long_issue_rd = 5'd9;
        step();
        long_issue_rd = 5'd8;
        step();
        long_issue = 0;
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd7; id_valid = 1; id_rs2 = 5'd7;
        step();
        ex_is_load = 0; ex_wen = 0; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs1 = 5'd9;
        long_issue = 1; long_issue_rd = 5'd11;
        step();
        long_issue = 0;
        #1;
        n_checks++; if (stall_id !== 1'b1 || sb_full !== 1'b1 || sb_err !== 1'b1) begin n_fail++; $display("FAIL ar_before: got stall=%b full=%b err=%b want 1 1 1", stall_id, sb_full, sb_err); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (stall_id !== 1'b0 || flush_ex !== 1'b0 || sb_full !== 1'b0 || sb_err !== 1'b0 || fwd_sel !== FWD_ALL_RF) begin
            n_fail++; $display("FAIL ar_immediate: got stall=%b flush=%b full=%b err=%b fwd=%b want 0 0 0 0 %b", stall_id, flush_ex, sb_full, sb_err, fwd_sel, FWD_ALL_RF);
        end
        rst_n = 1'b1;
        step();
        n_checks++; if (stall_id !== 1'b0 || sb_full !== 1'b0) begin n_fail++; $display("FAIL ar_after: got stall=%b full=%b want 0 0", stall_id, sb_full); end
        clear_inputs();
    endtask

    task automatic test_random();
        bit          m_pend [32];
        int          m_cnt, m_bub;
        bit          m_err;
        logic [NS*3-1:0] e_fwd;
        bit          e_stall, e_full, lu, sbh, full_raw, iss_ok, dn_ok;
        int          r;
        int          regs [3];
        int          pq [$];

        do_reset();
        foreach (m_pend[k]) m_pend[k] = 0;
        m_cnt = 0; m_bub = 0; m_err = 0;

        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) begin
                do_reset();
                foreach (m_pend[k]) m_pend[k] = 0;
                m_cnt = 0; m_bub = 0; m_err = 0;
            end
            for (int c = 0; c < NS; c++) ex_src_rs[c*AW +: AW] = AW'($urandom_range(0, 7));
            mem_rd = AW'($urandom_range(0, 7)); mem_wen = 1'($urandom_range(0, 1));
            wb_rd  = AW'($urandom_range(0, 7)); wb_wen  = 1'($urandom_range(0, 1));
            ex_rd  = AW'($urandom_range(0, 7)); ex_wen  = 1'($urandom_range(0, 1));
            ex_is_load = ($urandom_range(0, 3) == 0);
            id_rs1 = AW'($urandom_range(0, 7)); id_rs2 = AW'($urandom_range(0, 7));
            id_rd  = AW'($urandom_range(0, 7));
            id_valid   = ($urandom_range(0, 3) != 0);
            id_is_long = ($urandom_range(0, 3) == 0);
            long_issue = ($urandom_range(0, 3) == 0);
            long_issue_rd = AW'($urandom_range(0, 7));
            pq.delete();
            for (int k = 1; k < 32; k++) if (m_pend[k]) pq.push_back(k);
            long_done = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                long_done_rd = AW'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                long_done_rd = AW'($urandom_range(0, 7));
            #1;

            for (int c = 0; c < NS; c++) begin
                r = int'(ex_src_rs[c*AW +: AW]);
                if (mem_wen && mem_rd != 0 && r == int'(mem_rd)) e_fwd[c*3 +: 3] = 3'b010;
                else if (wb_wen && wb_rd != 0 && r == int'(wb_rd)) e_fwd[c*3 +: 3] = 3'b100;
                else e_fwd[c*3 +: 3] = 3'b001;
            end
            lu = id_valid && ex_is_load && ex_wen && ex_rd != 0 && (id_rs1 == ex_rd || id_rs2 == ex_rd);
            regs[0] = int'(id_rs1); regs[1] = int'(id_rs2); regs[2] = int'(id_rd);
            sbh = 0;
            foreach (regs[k]) begin
                if (id_valid && regs[k] != 0 && m_pend[regs[k]]) begin
`ifdef HAZ_SB_DONE_BYPASS_EN
                    if (!(long_done && int'(long_done_rd) == regs[k])) sbh = 1;
`else
                    sbh = 1;
`endif
                end
            end
            full_raw = (m_cnt == ML);
`ifdef HAZ_SB_DONE_BYPASS_EN
            e_full = full_raw && !long_done;
`else
            e_full = full_raw;
`endif
            e_stall = lu || (m_bub != 0) || sbh || (id_valid && id_is_long && e_full);

            n_checks++; if (fwd_sel !== e_fwd) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %b want %b", i, fwd_sel, e_fwd); end
            n_checks++; if (stall_id !== e_stall || flush_ex !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got stall=%b flush=%b want %b", i, stall_id, flush_ex, e_stall); end
            n_checks++; if (sb_full !== e_full) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, sb_full, e_full); end
            n_checks++; if (sb_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, sb_err, m_err); end

            @(posedge clk);
            if (m_bub != 0) m_bub = m_bub - 1;
            else if (lu) m_bub = LUB - 1;
            iss_ok = long_issue && (!full_raw || long_done);
            dn_ok  = long_done && (m_cnt > 0);
            if ((long_issue && !iss_ok) || (long_done && !dn_ok)) m_err = 1;
            if (dn_ok) m_pend[int'(long_done_rd)] = 0;
            if (iss_ok && long_issue_rd != 0) m_pend[int'(long_issue_rd)] = 1;
            m_cnt = m_cnt + int'(iss_ok) - int'(dn_ok);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_scoreboard();
        test_capacity();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
